// File: rtl/vm1_vic.sv
// vm1_vic: vectored interrupt controller.
// Collects device requests (level or rising-edge latched), picks the
// lowest-index pending line, raises virq and answers the CPU's vector
// fetch handshake (istb/iack/ivec), then pulses irq_ack to the served device.
module vm1_vic #(
    parameter int                    NREQ      = 4,
    parameter logic [16*NREQ-1:0]    VECTORS   = {16'o000304, 16'o000300, 16'o000064, 16'o000060},
    parameter logic [NREQ-1:0]       EDGE_MASK = 4'b1100
) (
    input  logic            clk_p,
    input  logic            rst_n,
    input  logic            vm_init,
    input  logic [NREQ-1:0] irq_req,
    output logic [NREQ-1:0] irq_ack,
    output logic            virq,
    input  logic            istb,
    output logic [15:0]     ivec,
    output logic            iack
);

    localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [SELW-1:0]   sel_reg;
    logic              virq_reg;
    logic              iack_reg;
    logic [15:0]       ivec_reg;
    logic [NREQ-1:0]   irq_ack_reg;

    logic [NREQ-1:0]   pend_reg;
    logic [NREQ-1:0]   pend_next;
    logic [NREQ-1:0]   hist_reg;
    logic [NREQ-1:0]   ack_clear;

    logic [SELW-1:0]   win;
    logic              any_pend;
    logic [15:0]       win_vec;

    // The ACK->GAP transition is the moment irq_ack[sel] goes high; edge
    // pending bits are cleared on that same edge so the pulse and the clear
    // line up, and a fresh edge arriving in that cycle still wins.
    assign ack_clear = (state_reg == ST_ACK && !istb) ? (NREQ'(1) << sel_reg) : '0;

    // Per-line next pending value: level lines follow the request, edge
    // lines latch a 0->1 transition until acknowledged.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pend
            if (EDGE_MASK[gi]) begin : g_edge
                assign pend_next[gi] = (irq_req[gi] & ~hist_reg[gi]) |
                                       (pend_reg[gi] & ~ack_clear[gi]);
            end else begin : g_level
                assign pend_next[gi] = irq_req[gi];
            end
        end
    endgenerate

    // Pending register; INIT clears it like reset does.
    always_ff @(posedge clk_p) begin
        if (!rst_n || vm_init) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // Edge-detect history survives INIT so a held level is not a new edge.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= irq_req;
        end
    end

    // Fixed-priority winner: lowest pending index.
    always_comb begin
        win      = '0;
        any_pend = |pend_reg;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                win = SELW'(i);
            end
        end
        win_vec = VECTORS[16*win +: 16] & 16'hFFFC;
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk_p) begin
        if (!rst_n || vm_init) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            virq_reg    <= 1'b0;
            iack_reg    <= 1'b0;
            ivec_reg    <= '0;
            irq_ack_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    virq_reg    <= 1'b0;
                    iack_reg    <= 1'b0;
                    irq_ack_reg <= '0;
                    if (any_pend) begin
                        sel_reg   <= win;
                        virq_reg  <= 1'b1;
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!any_pend) begin
                        virq_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (istb) begin
                        sel_reg   <= win;
                        ivec_reg  <= win_vec;
                        iack_reg  <= 1'b1;
                        virq_reg  <= 1'b0;
                        state_reg <= ST_ACK;
                    end else begin
                        sel_reg <= win;
                    end
                end
                ST_ACK: begin
                    if (!istb) begin
                        iack_reg    <= 1'b0;
                        ivec_reg    <= '0;
                        irq_ack_reg <= NREQ'(1) << sel_reg;
                        state_reg   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    irq_ack_reg <= '0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign virq    = virq_reg;
    assign iack    = iack_reg;
    assign ivec    = ivec_reg;
    assign irq_ack = irq_ack_reg;

endmodule

// File: doc/vm1_vic.md
Name: vm1_vic

Overview:
- Vectored interrupt controller between the peripheral devices and the processor board's vectored interrupt interface (virq, ivec, istb, iack).
- Collects up to NREQ device requests, latches edge-type requests, and arbitrates by fixed priority.
- Raises virq and answers the processor's vector-fetch handshake with the winner's vector.
- Pulses a per-line acknowledge back to the device whose vector was delivered.

Parameters:
- NREQ, 4, number of request lines; index 0 is the highest priority.
- VECTORS, {16'o000304,16'o000300,16'o000064,16'o000060}, packed 16*NREQ; line i's vector is bits [16*i+15:16*i]; bits [1:0] are always driven 0.
- EDGE_MASK, 4'b1100, bit i=1 means line i is rising-edge latched; 0 means level.

Ports:
- clk_p  in  1  bus clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- vm_init  in  1  processor INIT; same effect as reset except the edge-detect history is kept.
- irq_req  in  NREQ  device requests, synchronous to clk_p.
- irq_ack  out  NREQ  one-cycle pulse to the served device.
- virq  out  1  vectored request to the CPU.
- istb  in  1  vector-fetch strobe from the CPU.
- ivec  out  16  vector data.
- iack  out  1  vector-fetch acknowledge.

Behaviour:
- Reset (rst_n=0 at clock edge): virq=0, iack=0, ivec=0, irq_ack=0, pending=0, edge history=0, state=IDLE.
- vm_init=1: same as reset, except edge history is kept, so a level already high is not seen as a new edge.
- Pending vector: pend[i] = irq_req[i] for level lines.
  - Edge lines: pend[i] is set on a 0->1 transition of irq_req[i] (registered history).
  - Edge pend[i] clears only when irq_ack[i] pulses.
  - If a set and a clear of the same edge line fall in one cycle, the set wins.
- Winner: lowest index i with pend[i]=1, computed combinationally from pend.
- FSM states:
  - IDLE: virq=0. If any pend bit is set, latch winner index into sel, go to REQ. virq=1 from the next cycle, so latency from request to virq is 2 clocks.
  - REQ: virq=1; sel is re-evaluated every cycle, so a higher-priority arrival preempts the choice before istb.
    - If pend becomes all-zero (level request withdrawn) before istb: virq=0, go to IDLE; no irq_ack is issued.
    - istb=1: freeze sel, drive ivec=VECTORS[sel] with [1:0] forced to 0, iack=1 on the next cycle, go to ACK.
  - ACK: virq=0, iack=1, ivec held stable. Withdrawal of the request is ignored; the vector is committed. When istb=0: iack=0, ivec=0, irq_ack[sel]=1 for exactly one cycle, go to GAP.
  - GAP: one idle cycle so the device can drop its level request, then IDLE. virq stays 0 in GAP.
- istb=1 seen in IDLE or GAP: ignored; iack stays 0. The CPU then times out; this is a CPU-side error, not a controller error.
- Never more than one irq_ack bit high at a time; irq_ack only pulses on the ACK->GAP transition.
- Reset or vm_init in any state: immediate return to IDLE with all outputs 0. No irq_ack is issued for an aborted fetch.
- Combinational paths: pend to winner only. All outputs are registered.

Test Plan:
- Level request: irq_req=4'b0001 held. virq rises 2 clocks later. Drive istb=1: iack=1 next cycle, ivec=16'o000060. Drop istb: irq_ack=4'b0001 for 1 cycle, then virq stays 0 through GAP.
- Priority: irq_req=4'b1010 simultaneously. Full handshake gives ivec=16'o000064 and irq_ack=4'b0010. After GAP with line 1 released, a second handshake gives ivec=16'o000304 and irq_ack=4'b1000.
- Preemption and withdrawal:
  - Line 2 pending in REQ, then line 0 asserted before istb: fetch returns 16'o000060.
  - Separately, line 0 dropped in REQ with nothing else pending: virq=0, state IDLE, irq_ack stays 0.
- Edge latching: 1-cycle pulse on irq_req[3].
  - pend[3] holds and the fetch returns 16'o000304.
  - A second pulse during ACK re-sets pend[3], so a second request follows after GAP.
  - Holding irq_req[3] high produces only one request.
- Reset mid-fetch: rst_n=0 during ACK with istb=1. Next cycle iack=0, ivec=0, virq=0, irq_ack=0. After release with the level request still high, the request is re-raised in 2 clocks.
- vm_init: irq_req[2] held high, pulse vm_init. Pending is cleared and the edge history is kept, so no new request appears until irq_req[2] falls and rises again.
